// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// A fetch_entry_t pairs a returned instruction word with the PC it was fetched from.
package ifu_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifu_if.sv
// Fetch unit bus: the imem request/response channel, the redirect input and the decode-side valid/ready port.
// The master modport is the fetch unit itself; the slave modport is the memory/decode environment.
interface ifu_if;
  import ifu_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               inst_valid;
  logic               inst_ready;
  logic [INSTR_W-1:0] inst;
  logic [PC_W-1:0]    inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ifu_fifo.sv
// First-word-fall-through buffer of fetched {pc, inst} entries.
// Head is read straight from storage; a push is visible at the head the following cycle.
module ifu_fifo import ifu_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  fetch_entry_t               i_push_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output fetch_entry_t               o_head,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_pop && !i_flush && r_count == CW'(DEPTH)));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(i_pop && !i_flush && r_count == '0));
endmodule

// File: rtl/instruction_fetch_unit.sv
// Front-end fetch stage: owns the PC, issues credit-limited imem requests, buffers in-order responses,
// and on redirect flushes the buffer and discards every response still in flight.
module instruction_fetch_unit import ifu_pkg::*; #(
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic   clk,
  input logic   rst,
  ifu_if.master bus
);
  localparam int OW = $clog2(MAX_OUT+1);
  localparam int CW = $clog2(DEPTH+1);

  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_resp_pc;
  logic [OW-1:0]   r_outstanding;
  logic [OW-1:0]   r_discard;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_inflight;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;
  logic            w_empty;
  logic            w_req;
  logic            w_accept;
  logic            w_rsp;
  logic            w_push;
  logic            w_inst_valid;
  logic            w_pop;
  logic [PC_W-1:0] w_redirect_pc;

  assign w_redirect_pc = word_align(bus.redirect_pc);

  // Credit: every outstanding request already owns a buffer slot, so the FIFO can never overflow.
  assign w_inflight = (CW+1)'(r_outstanding) + (CW+1)'(w_count);
  assign w_req      = !rst && !bus.redirect
                   && (r_outstanding < OW'(MAX_OUT))
                   && (w_inflight < (CW+1)'(DEPTH));
  assign w_accept   = w_req && bus.imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp        = bus.imem_rvalid && (r_outstanding != '0);
  assign w_push       = w_rsp && !bus.redirect && (r_discard == '0);
  assign w_inst_valid = !w_empty && !bus.redirect;
  assign w_pop        = w_inst_valid && bus.inst_ready;
  assign w_push_data  = '{pc: r_resp_pc, inst: bus.imem_rdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      // Outstanding cannot overflow: accept only happens below MAX_OUT.
      r_outstanding <= r_outstanding + OW'(w_accept) - OW'(w_rsp);
      if (bus.redirect) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_discard  <= r_outstanding - OW'(w_rsp);
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (w_push)   r_resp_pc  <= r_resp_pc + PC_STEP;
        if (w_rsp && r_discard != '0) r_discard <= r_discard - OW'(1);
      end
    end
  end

  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (bus.redirect),
    .o_count     (w_count),
    .o_head      (w_head),
    .o_empty     (w_empty)
  );

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = r_fetch_pc;
  assign bus.inst_valid = w_inst_valid;
  assign bus.inst       = w_head.inst;
  assign bus.inst_pc    = w_head.pc;

  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (w_req && !bus.imem_gnt) |=> (bus.redirect || (w_req && $stable(r_fetch_pc))));

  a_discard_bounded: assert property (@(posedge clk) disable iff (rst)
    r_discard <= r_outstanding);
endmodule
